// File: rtl/prog_counter_gen_pkg.sv
// Shared mode encoding and default sizing for the programmable edge counter.
// No logic; latency and backpressure not applicable.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RELOAD  = 2'b11
  } mode_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/prog_counter_gen_if.sv
// Control and status bundle of the programmable edge counter.
// Pure wiring; latency and backpressure not applicable.
interface prog_counter_gen_if #(parameter int WIDTH = 8);
  import prog_counter_pkg::*;

  logic             enable;
  logic             cnt_in;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_down;
  mode_e            mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;
  logic             at_max;
  logic             at_zero;

  modport master (
    output enable, cnt_in, load, load_val, up_down, mode, limit,
    input  count, tc, done, at_max, at_zero
  );

  modport slave (
    input  enable, cnt_in, load, load_val, up_down, mode, limit,
    output count, tc, done, at_max, at_zero
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchroniser for an async strobe plus single-cycle rising-edge pulse.
// Latency: rise asserts STAGES cycles after din is first sampled high; no backpressure.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/prog_counter_gen.sv
// Programmable up/down counter of cnt_in rising edges with limit, four boundary modes, tc pulse.
// Latency: count moves SYNC_STAGES edges after cnt_in is sampled high; no backpressure.
module prog_counter_gen
  import prog_counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  prog_counter_gen_if.slave bus
);

  logic             rise;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.cnt_in),
    .rise (rise)
  );

  // Edge history keeps running while disabled, so enable only masks the pulse.
  assign step = rise & bus.enable;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    boundary = bus.up_down ? (count_q >= bus.limit) : (count_q == '0);

    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      done_d   = 1'b0;
    end else if (step && !(done_q && bus.mode == MODE_ONESHOT)) begin
      if (boundary) begin
        tc_d = 1'b1;
        unique case (bus.mode)
          MODE_WRAP:    count_d = bus.up_down ? '0 : bus.limit;
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: done_d  = 1'b1;
          MODE_RELOAD:  count_d = reload_q;
        endcase
      end else begin
        count_d = bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.done    = done_q;
  assign bus.at_max  = (count_q >= bus.limit);
  assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_prog_counter_gen.sv
// Scoreboarded bench: directed test-plan sequences then random traffic vs an event-level model.
module tb_prog_counter_gen;
  import prog_counter_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    int count;
    int tc;
    int done;
    int at_max;
    int at_zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_counter_gen_if #(.WIDTH(W)) bus ();

  prog_counter_gen #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Reference model state: cnt_in samples seen at each edge, newest last.
  int samples[$];
  int m_count, m_reload, m_done;
  int tc_seen;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count",   int'(bus.count),   e.count);
      check("tc",      int'(bus.tc),      e.tc);
      check("done",    int'(bus.done),    e.done);
      check("at_max",  int'(bus.at_max),  e.at_max);
      check("at_zero", int'(bus.at_zero), e.at_zero);
      if (bus.tc) tc_seen++;
    end
  end

  // Predict the outcome of the coming edge from the inputs now on the bus.
  task automatic tick();
    exp_t e;
    int   lim, step, up;
    lim = int'(bus.limit);
    up  = int'(bus.up_down);
    e.tc = 0;
    if (rst) begin
      m_count = 0; m_reload = 0; m_done = 0;
      samples.delete();
      for (int i = 0; i <= S; i++) samples.push_back(0);
    end else begin
      // A step lands S edges after cnt_in was first seen high following a low sample.
      step = samples[samples.size()-S] & ~samples[samples.size()-S-1] & int'(bus.enable);
      if (bus.load) begin
        m_count = int'(bus.load_val); m_reload = m_count; m_done = 0;
      end else if (step != 0 && !(m_done != 0 && bus.mode == MODE_ONESHOT)) begin
        if ((up != 0 && m_count >= lim) || (up == 0 && m_count == 0)) begin
          e.tc = 1;
          case (bus.mode)
            MODE_WRAP:    m_count = (up != 0) ? 0 : lim;
            MODE_ONESHOT: m_done = 1;
            MODE_RELOAD:  m_count = m_reload;
            default:      ;
          endcase
        end else begin
          m_count = (up != 0) ? m_count + 1 : m_count - 1;
        end
      end
      samples.push_back(int'(bus.cnt_in));
      void'(samples.pop_front());
    end
    e.count   = m_count;
    e.done    = m_done;
    e.at_max  = (m_count >= lim) ? 1 : 0;
    e.at_zero = (m_count == 0) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.cnt_in = 1'b1;
    repeat (hi) tick();
    bus.cnt_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_load(input int v);
    bus.load = 1'b1; bus.load_val = W'(v);
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    bus.enable = 1'b1; bus.cnt_in = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.up_down = 1'b1; bus.mode = MODE_WRAP; bus.limit = 8'd5;
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;
    check("reset_count", int'(bus.count), 0);
    check("reset_done",  int'(bus.done),  0);

    // WRAP up to 5: 1,2,3,4,5,0,1 with a single tc on 5->0.
    tc_seen = 0;
    repeat (7) pulse(1, 2);
    check("wrap_final", int'(bus.count), 1);
    check("wrap_tcs",   tc_seen, 1);

    // SAT down from 2: 1,0,0,0; two tcs.
    bus.mode = MODE_SAT; bus.up_down = 1'b0;
    do_load(2);
    tc_seen = 0;
    repeat (4) pulse(1, 2);
    check("sat_final", int'(bus.count), 0);
    check("sat_zero",  int'(bus.at_zero), 1);
    check("sat_tcs",   tc_seen, 2);

    // ONESHOT up to 3 from 2: 3,3 then halted.
    bus.mode = MODE_ONESHOT; bus.up_down = 1'b1; bus.limit = 8'd3;
    do_load(2);
    tc_seen = 0;
    repeat (4) pulse(1, 2);
    check("oneshot_count", int'(bus.count), 3);
    check("oneshot_done",  int'(bus.done), 1);
    check("oneshot_tcs",   tc_seen, 1);
    do_load(0);
    check("oneshot_clear", int'(bus.done), 0);

    // RELOAD down from 2: 1,0,2,1,0.
    bus.mode = MODE_RELOAD; bus.up_down = 1'b0; bus.limit = 8'd9;
    do_load(2);
    tc_seen = 0;
    repeat (5) pulse(1, 2);
    check("reload_final", int'(bus.count), 0);
    check("reload_tcs",   tc_seen, 1);

    // Long high input gives one step; re-enabling while high gives none.
    bus.mode = MODE_WRAP; bus.up_down = 1'b1;
    c0 = int'(bus.count);
    bus.cnt_in = 1'b1;
    repeat (5) tick();
    bus.enable = 1'b0;
    repeat (5) tick();
    bus.enable = 1'b1;
    repeat (10) tick();
    bus.cnt_in = 1'b0;
    repeat (3) tick();
    check("long_high_one_step", int'(bus.count), c0 + 1);

    // Load coincident with a step wins and drops the step.
    bus.cnt_in = 1'b1;
    repeat (2) tick();
    bus.load = 1'b1; bus.load_val = 8'd7;
    tick();
    bus.load = 1'b0; bus.cnt_in = 1'b0;
    check("load_prio_count", int'(bus.count), 7);
    check("load_prio_tc",    int'(bus.tc), 0);

    // Reset with a load and a step in flight clears everything.
    bus.cnt_in = 1'b1;
    tick();
    rst = 1'b1; bus.load = 1'b1; bus.cnt_in = 1'b0;
    tick();
    rst = 1'b0; bus.load = 1'b0;
    check("rst_prio_count", int'(bus.count), 0);
    repeat (4) tick();
    check("rst_no_late_step", int'(bus.count), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = W'($urandom_range(0, 12));
      bus.cnt_in   = ($urandom_range(0, 2) == 0) ? ~bus.cnt_in : bus.cnt_in;
      bus.enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) bus.up_down = ~bus.up_down;
      if ($urandom_range(0, 29) == 0) bus.mode = mode_e'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.limit = W'($urandom_range(0, 10));
      tick();
    end
    rst = 1'b0; bus.load = 1'b0;
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
